// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller with a single-outstanding SRAM access FSM.
// Memory freezes take priority over branch flushes, and branch flushes over hazard stalls.
module pipeline_controller (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        hazard_i,
   input  logic        branch_taken_i,
   input  logic        mem_r_en_i,
   input  logic        mem_w_en_i,
   input  logic        sram_ready_i,
   output logic        sram_start_o,
   output logic        freeze_all_o,
   output logic        freeze_front_o,
   output logic        id_bubble_o,
   output logic        flush_if_o,
   output logic        mem_error_o,
   output logic [15:0] stall_count_o,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StMemWait = 2'b01,
      StMemDone = 2'b10,
      StErr     = 2'b11
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        mem_req;
   logic        start;
   logic        freeze_all;
   logic        freeze_front;

   assign mem_req = mem_r_en_i | mem_w_en_i;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      start      = 1'b0;
      freeze_all = 1'b0;
      case (state_q)
         StIdle: begin
            if (mem_req) begin
               start      = 1'b1;
               freeze_all = 1'b1;
               state_d    = StMemWait;
               wait_cnt_d = 8'd0;
            end
         end
         StMemWait: begin
            freeze_all = 1'b1;
            if (sram_ready_i) begin
               state_d = StMemDone;
            end else if (wait_cnt_q == 8'hFF) begin
               state_d = StErr;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         // One idle-like cycle so a still-asserted request cannot relaunch immediately.
         StMemDone: state_d = StIdle;
         StErr:     freeze_all = 1'b1;
         default:   state_d = StIdle;
      endcase
   end

   assign freeze_front = hazard_i & ~branch_taken_i & ~freeze_all;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((freeze_all | freeze_front) && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         wait_cnt_q  <= 8'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Combinational outputs are gated so nothing leaks out while reset is held.
   assign sram_start_o   = start & rst_ni;
   assign freeze_all_o   = freeze_all & rst_ni;
   assign freeze_front_o = freeze_front & rst_ni;
   assign flush_if_o     = branch_taken_i & ~freeze_all & rst_ni;
   assign id_bubble_o    = (branch_taken_i | hazard_i) & ~freeze_all & rst_ni;
   assign mem_error_o    = (state_q == StErr) & rst_ni;
   assign stall_count_o  = stall_cnt_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a behavioural model and
// queues them; the monitor pops and compares at the falling edge.
module tb_pipeline_controller;

   logic        clk;
   logic        rst_n;
   logic        hazard, branch_taken, mem_r_en, mem_w_en, sram_ready;
   logic        sram_start, freeze_all, freeze_front, id_bubble, flush_if, mem_error;
   logic [15:0] stall_count;
   logic [1:0]  state;

   pipeline_controller dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .hazard_i       (hazard),
      .branch_taken_i (branch_taken),
      .mem_r_en_i     (mem_r_en),
      .mem_w_en_i     (mem_w_en),
      .sram_ready_i   (sram_ready),
      .sram_start_o   (sram_start),
      .freeze_all_o   (freeze_all),
      .freeze_front_o (freeze_front),
      .id_bubble_o    (id_bubble),
      .flush_if_o     (flush_if),
      .mem_error_o    (mem_error),
      .stall_count_o  (stall_count),
      .state_o        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit drv_done = 1'b0;

   typedef struct {
      logic [23:0] vec;
      int          cyc;
      string       tag;
   } exp_t;
   exp_t exp_q[$];

   // Behavioural model: where the memory access is, how long it has waited, stalls so far.
   bit busy;        // access launched, waiting for ready
   bit just_done;   // ready seen last cycle
   bit errored;     // timed out
   int waited;      // not-ready cycles spent waiting
   int stalls;

   task automatic model_reset();
      busy = 0; just_done = 0; errored = 0; waited = 0; stalls = 0;
   endtask

   task automatic step(input string tag, input bit rst, input bit hz, input bit br,
                       input bit r, input bit w, input bit rdy);
      bit req, fa, ff, st, fl, bb, er;
      int sv;
      exp_t e;
      @(posedge clk);
      #2;
      rst_n = rst; hazard = hz; branch_taken = br; mem_r_en = r; mem_w_en = w;
      sram_ready = rdy;
      cyc++;
      if (!rst) begin
         model_reset();
         e.vec = 24'd0;
      end else begin
         req = r | w;
         st  = !busy && !just_done && !errored && req;
         fa  = st || busy || errored;
         ff  = hz && !br && !fa;
         fl  = br && !fa;
         bb  = (br || hz) && !fa;
         er  = errored;
         sv  = errored ? 3 : busy ? 1 : just_done ? 2 : 0;
         e.vec = {st, fa, ff, bb, fl, er, sv[1:0], stalls[15:0]};
         if ((fa || ff) && stalls < 65535) stalls++;
         if (just_done) begin
            just_done = 0;
         end else if (busy) begin
            if (rdy) begin
               busy = 0; just_done = 1;
            end else begin
               waited++;
               if (waited == 256) begin
                  busy = 0; errored = 1;
               end
            end
         end else if (st) begin
            busy = 1; waited = 0;
         end
      end
      e.cyc = cyc;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   // Monitor: compares whatever the driver has queued, one entry per falling edge.
   initial begin
      exp_t e;
      logic [23:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {sram_start, freeze_all, freeze_front, id_bubble, flush_if, mem_error,
                   state, stall_count};
            tests++;
            if (act !== e.vec) begin
               fails++;
               $display("FAIL %s cyc %0d: got start/fa/ff/bub/fl/err=%b state=%b stall=%0d, want %b state=%b stall=%0d",
                        e.tag, e.cyc, act[23:18], act[17:16], act[15:0],
                        e.vec[23:18], e.vec[17:16], e.vec[15:0]);
            end
         end
      end
   end

   initial begin
      model_reset();
      rst_n = 1'b0; hazard = 0; branch_taken = 0; mem_r_en = 0; mem_w_en = 0; sram_ready = 0;
      // Reset held with noisy inputs: everything must stay at zero.
      for (int i = 0; i < 3; i++) step("reset_hold", 0, 1, 1, 1, 1, 1);
      // Read with ready on the 3rd wait cycle.
      step("rd3_req", 1, 0, 0, 1, 0, 0);
      step("rd3_w1", 1, 0, 0, 1, 0, 0);
      step("rd3_w2", 1, 0, 0, 1, 0, 0);
      step("rd3_w3", 1, 0, 0, 1, 0, 1);
      step("rd3_done", 1, 0, 0, 0, 0, 0);
      step("rd3_idle", 1, 0, 0, 0, 0, 0);
      // Hazard only, then branch plus hazard.
      step("haz1", 1, 1, 0, 0, 0, 0);
      step("haz2", 1, 1, 0, 0, 0, 0);
      step("br_haz", 1, 1, 1, 0, 0, 0);
      step("idle_ready", 1, 0, 0, 0, 0, 1);
      // Branch held across a write freeze: flush only once MEM_DONE is reached.
      step("brfz_req", 1, 0, 1, 0, 1, 0);
      step("brfz_w1", 1, 0, 1, 0, 1, 0);
      step("brfz_w2", 1, 1, 1, 0, 1, 1);
      step("brfz_done", 1, 0, 1, 0, 1, 0);
      step("brfz_idle", 1, 0, 0, 0, 0, 0);
      // Back-to-back reads with immediate ready.
      for (int i = 0; i < 6; i++) step("b2b", 1, 0, 0, 1, 0, 1);
      // Async reset mid-access.
      step("mid_req", 1, 0, 0, 1, 0, 0);
      step("mid_wait", 1, 0, 0, 1, 0, 0);
      step("mid_rst", 0, 0, 0, 1, 0, 0);
      step("mid_rel", 1, 0, 0, 1, 0, 1);
      step("mid_wait2", 1, 0, 0, 0, 0, 1);
      step("mid_done", 1, 0, 0, 0, 0, 0);
      // Timeout: ready never arrives, then stays in error until reset.
      step("to_req", 1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 300; i++)
         step("timeout", 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1, 0);
      step("to_ready", 1, 1, 1, 1, 0, 1);
      step("to_rst", 0, 0, 0, 1, 1, 0);
      step("to_rel", 1, 0, 0, 0, 0, 0);
      // Random traffic with occasional reset pulses.
      for (int i = 0; i < 4000; i++) begin
         step("random", ($urandom_range(0, 199) != 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0));
      end
      // Long wait that ends just before the timeout boundary.
      step("edge_req", 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 255; i++) step("edge_wait", 1, 0, 0, 1, 0, 0);
      step("edge_ready", 1, 0, 0, 0, 0, 1);
      step("edge_done", 1, 0, 0, 0, 0, 0);
      step("edge_idle", 1, 1, 0, 0, 0, 0);
      drv_done = 1'b1;
   end

   initial begin
      int budget;
      budget = 0;
      wait (drv_done);
      while (exp_q.size() > 0 && budget < 10) begin
         @(posedge clk);
         budget++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
